// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter
//   Shared random-number service: one 16-bit Fibonacci LFSR
//   (x^16+x^14+x^13+x^11+1) arbitrated round-robin among NUM_REQ requesters.
//   Each grant advances the LFSR STEPS times, then the fresh word is offered
//   to the granted requester over a valid/ack handshake. The block also owns
//   seeding; a zero seed is replaced by SEED so the LFSR never locks up.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   req        in   [NUM_REQ] level-sensitive requests
//   ack        in   [NUM_REQ] acceptance, only the granted bit is honoured
//   grant      out  [NUM_REQ] one-hot grant, RUN entry until the ack cycle
//   rnd_out    out  [16] delivered word, stable while rnd_valid
//   rnd_valid  out  rnd_out valid for the granted requester
//   seed_load  in   load seed_in into the LFSR (IDLE only)
//   seed_in    in   [16] seed value
//   busy       out  FSM not in IDLE
//   lfsr_state out  [16] current LFSR register (debug)
module lfsr_rng_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned STEPS   = 16,
  parameter logic [15:0] SEED    = 16'h5678
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] grant,
  output logic [15:0]        rnd_out,
  output logic               rnd_valid,
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
  output logic               busy,
  output logic [15:0]        lfsr_state
);

  localparam int unsigned        IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]         LAST = 8'(STEPS - 1);
  localparam logic [NUM_REQ-1:0] ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [15:0]        rnd_q, rnd_d;
  logic               valid_q, valid_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  int unsigned        cand;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Round-robin pick: scan from ptr+1 with wrap; the last candidate visited
  // is ptr itself, so a lone requester is re-served after its own grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && req[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed_in == '0) ? SEED : seed_in;
        end else if (pick_found) begin
          gidx_d  = pick_idx;
          grant_d = ONE << pick_idx;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == LAST) begin
          rnd_d   = lfsr_d;
          valid_d = 1'b1;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (ack[gidx_q]) begin
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = gidx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
    end
  end

  assign grant      = grant_q;
  assign rnd_out    = rnd_q;
  assign rnd_valid  = valid_q;
  assign busy       = (state_q != IDLE);
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
module tb_lfsr_rng_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: STEPS=1, instance b: STEPS=16
  logic        a_reset, a_seed_load, a_rnd_valid, a_busy;
  logic [3:0]  a_req, a_ack, a_grant;
  logic [15:0] a_seed_in, a_rnd_out, a_lfsr;
  logic        b_reset, b_seed_load, b_rnd_valid, b_busy;
  logic [3:0]  b_req, b_ack, b_grant;
  logic [15:0] b_seed_in, b_rnd_out, b_lfsr;

  lfsr_rng_arbiter #(.NUM_REQ(4), .STEPS(1), .SEED(16'h5678)) dut_a (
    .clk(clk), .reset(a_reset), .req(a_req), .ack(a_ack), .grant(a_grant),
    .rnd_out(a_rnd_out), .rnd_valid(a_rnd_valid), .seed_load(a_seed_load),
    .seed_in(a_seed_in), .busy(a_busy), .lfsr_state(a_lfsr));

  lfsr_rng_arbiter #(.NUM_REQ(4), .STEPS(16), .SEED(16'h5678)) dut_b (
    .clk(clk), .reset(b_reset), .req(b_req), .ack(b_ack), .grant(b_grant),
    .rnd_out(b_rnd_out), .rnd_valid(b_rnd_valid), .seed_load(b_seed_load),
    .seed_in(b_seed_in), .busy(b_busy), .lfsr_state(b_lfsr));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] stepm(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | 16'(fb);
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = stepm(r);
    return r;
  endfunction

  typedef struct {
    logic [15:0] lfsr;
    logic [15:0] rnd;
    bit          busy;
    bit          valid;
    int          left;
    int          gidx;
    int          ptr;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.lfsr = 16'h5678; m.rnd = 16'h0; m.busy = 0; m.valid = 0;
    m.left = 0; m.gidx = 0; m.ptr = 3;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int steps, input logic rst,
                                    input logic sl, input logic [15:0] si,
                                    input logic [3:0] rq, input logic [3:0] ak);
    mdl_t n;
    n = m;
    if (rst) return mdl_reset();
    if (!m.busy) begin
      if (sl) n.lfsr = (si == 16'h0) ? 16'h5678 : si;
      else if (rq != 4'h0) begin
        for (int k = 4; k >= 1; k--)
          if (rq[(m.ptr + k) % 4]) n.gidx = (m.ptr + k) % 4;
        n.busy = 1; n.left = steps;
      end
    end else if (!m.valid) begin
      n.lfsr = stepm(m.lfsr);
      n.left = m.left - 1;
      if (n.left == 0) begin n.valid = 1; n.rnd = n.lfsr; end
    end else if (ak[m.gidx]) begin
      n.busy = 0; n.valid = 0; n.ptr = m.gidx;
    end
    return n;
  endfunction

  function automatic logic [3:0] mgrant(input mdl_t m);
    return m.busy ? 4'(1 << m.gidx) : 4'h0;
  endfunction

  // ---------------- vector table for instance a ----------------
  typedef struct {
    logic        sl;
    logic [15:0] si;
    logic [3:0]  rq;
    logic [3:0]  ak;
    logic [3:0]  g;
    logic        v;
    logic [15:0] r;
    logic        b;
    logic [15:0] l;
  } vec_t;

  vec_t tbl[18];

  task automatic reset_b();
    b_reset = 1'b1; tick(); b_reset = 1'b0;
  endtask

  task automatic wait_b_valid(input string nm);
    int n;
    n = 0;
    while (!b_rnd_valid && n < 40) begin tick(); n++; end
    chk({nm, " valid within bound"}, 32'(b_rnd_valid), 32'd1);
  endtask

  initial begin
    logic [3:0]  rr_g[$];
    int          rr_t[$];
    logic        prev_v;
    logic [15:0] held;
    mdl_t        ma, mb;

    tbl[0]  = '{1'b0, 16'h0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 16'h0000, 1'b1, 16'h5678};
    tbl[1]  = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'hACF0, 1'b1, 16'hACF0};
    tbl[2]  = '{1'b0, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 16'hACF0, 1'b0, 16'hACF0};
    tbl[3]  = '{1'b0, 16'h0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 16'hACF0, 1'b1, 16'hACF0};
    tbl[4]  = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'h59E1, 1'b1, 16'h59E1};
    tbl[5]  = '{1'b0, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 16'h59E1, 1'b0, 16'h59E1};
    tbl[6]  = '{1'b1, 16'h0001, 4'b0010, 4'b0000, 4'b0000, 1'b0, 16'h59E1, 1'b0, 16'h0001};
    tbl[7]  = '{1'b0, 16'h0000, 4'b0010, 4'b0000, 4'b0010, 1'b0, 16'h59E1, 1'b1, 16'h0001};
    tbl[8]  = '{1'b1, 16'h1234, 4'b0000, 4'b0000, 4'b0010, 1'b1, 16'h0002, 1'b1, 16'h0002};
    tbl[9]  = '{1'b0, 16'h0000, 4'b0000, 4'b0001, 4'b0010, 1'b1, 16'h0002, 1'b1, 16'h0002};
    tbl[10] = '{1'b0, 16'h0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 16'h0002, 1'b0, 16'h0002};
    tbl[11] = '{1'b1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0002, 1'b0, 16'h5678};
    tbl[12] = '{1'b0, 16'h0000, 4'b1001, 4'b0000, 4'b1000, 1'b0, 16'h0002, 1'b1, 16'h5678};
    tbl[13] = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b1000, 1'b1, 16'hACF0, 1'b1, 16'hACF0};
    tbl[14] = '{1'b0, 16'h0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 16'hACF0, 1'b0, 16'hACF0};
    tbl[15] = '{1'b0, 16'h0000, 4'b1001, 4'b0000, 4'b0001, 1'b0, 16'hACF0, 1'b1, 16'hACF0};
    tbl[16] = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 16'h59E1, 1'b1, 16'h59E1};
    tbl[17] = '{1'b0, 16'h0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 16'h59E1, 1'b0, 16'h59E1};

    a_reset = 1'b1; a_req = '0; a_ack = '0; a_seed_load = 1'b0; a_seed_in = '0;
    b_reset = 1'b1; b_req = '0; b_ack = '0; b_seed_load = 1'b0; b_seed_in = '0;
    tick(); tick();

    chk("reset a grant", 32'(a_grant), 32'h0);
    chk("reset a valid", 32'(a_rnd_valid), 32'h0);
    chk("reset a rnd",   32'(a_rnd_out), 32'h0);
    chk("reset a busy",  32'(a_busy), 32'h0);
    chk("reset a lfsr",  32'(a_lfsr), 32'h5678);
    chk("reset b busy",  32'(b_busy), 32'h0);
    chk("reset b lfsr",  32'(b_lfsr), 32'h5678);
    a_reset = 1'b0; b_reset = 1'b0;

    // ---- table-driven vectors on instance a ----
    foreach (tbl[i]) begin
      a_seed_load = tbl[i].sl; a_seed_in = tbl[i].si; a_req = tbl[i].rq; a_ack = tbl[i].ak;
      tick();
      chk($sformatf("row%0d grant", i), 32'(a_grant), 32'(tbl[i].g));
      chk($sformatf("row%0d valid", i), 32'(a_rnd_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d rnd", i),   32'(a_rnd_out), 32'(tbl[i].r));
      chk($sformatf("row%0d busy", i),  32'(a_busy), 32'(tbl[i].b));
      chk($sformatf("row%0d lfsr", i),  32'(a_lfsr), 32'(tbl[i].l));
    end
    a_seed_load = 1'b0; a_req = '0; a_ack = '0;

    // ---- round-robin with all requests held, same-cycle ack ----
    b_req = 4'b1111; prev_v = 1'b0;
    for (int c = 0; c < 120 && rr_g.size() < 5; c++) begin
      tick();
      if (b_rnd_valid && !prev_v) begin rr_g.push_back(b_grant); rr_t.push_back(c); end
      prev_v = b_rnd_valid;
      b_ack  = b_rnd_valid ? b_grant : 4'h0;
    end
    chk("rr count", 32'(rr_g.size()), 32'd5);
    if (rr_g.size() == 5) begin
      chk("rr g0", 32'(rr_g[0]), 32'h1);
      chk("rr g1", 32'(rr_g[1]), 32'h2);
      chk("rr g2", 32'(rr_g[2]), 32'h4);
      chk("rr g3", 32'(rr_g[3]), 32'h8);
      chk("rr g4", 32'(rr_g[4]), 32'h1);
      for (int k = 1; k < 5; k++)
        chk($sformatf("rr spacing%0d", k), 32'(rr_t[k] - rr_t[k-1]), 32'd18);
    end
    b_req = '0; b_ack = '0;

    // ---- wrong ack and slow consumer on requester 2 ----
    reset_b();
    b_req = 4'b0100; tick();
    chk("slow grant", 32'(b_grant), 32'h4);
    b_req = 4'b0000;
    wait_b_valid("slow");
    chk("slow rnd", 32'(b_rnd_out), 32'(adv(16'h5678, 16)));
    held = b_rnd_out;
    b_ack = 4'b0010; tick();
    chk("wrong ack valid", 32'(b_rnd_valid), 32'd1);
    chk("wrong ack grant", 32'(b_grant), 32'h4);
    b_ack = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("slow%0d valid", k), 32'(b_rnd_valid), 32'd1);
      chk($sformatf("slow%0d rnd", k),   32'(b_rnd_out), 32'(held));
      chk($sformatf("slow%0d grant", k), 32'(b_grant), 32'h4);
    end
    b_ack = 4'b0100; tick(); b_ack = '0;
    chk("slow done grant", 32'(b_grant), 32'h0);
    chk("slow done valid", 32'(b_rnd_valid), 32'h0);
    chk("slow done busy",  32'(b_busy), 32'h0);

    // ---- seed_load during RUN is ignored ----
    reset_b();
    b_req = 4'b0001; tick(); b_req = '0;
    b_seed_load = 1'b1; b_seed_in = 16'h1234;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("seed run lfsr%0d", k), 32'(b_lfsr), 32'(adv(16'h5678, k)));
    end
    b_seed_load = 1'b0;
    wait_b_valid("seed run");
    b_ack = 4'b0001; tick(); b_ack = '0;

    // ---- reset on RUN cycle 5; pointer returns to requester 0 priority ----
    b_req = 4'b0010; tick(); b_req = '0;
    chk("rst run grant", 32'(b_grant), 32'h2);
    tick(); tick(); tick(); tick();
    b_reset = 1'b1; tick(); b_reset = 1'b0;
    chk("rst mid grant", 32'(b_grant), 32'h0);
    chk("rst mid valid", 32'(b_rnd_valid), 32'h0);
    chk("rst mid lfsr",  32'(b_lfsr), 32'h5678);
    chk("rst mid busy",  32'(b_busy), 32'h0);
    b_req = 4'b1111; tick(); b_req = '0;
    chk("rst mid next grant", 32'(b_grant), 32'h1);

    // ---- randomized run of both instances against the model ----
    for (int c = 0; c < 3000; c++) begin
      a_reset = (c == 0) || ($urandom_range(0, 299) == 0);
      b_reset = (c == 0) || ($urandom_range(0, 299) == 0);
      a_req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      b_req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      a_ack = 4'($urandom); b_ack = 4'($urandom);
      a_seed_load = ($urandom_range(0, 15) == 0);
      b_seed_load = ($urandom_range(0, 15) == 0);
      a_seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      b_seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
      ma = mdl_next(ma, 1,  a_reset, a_seed_load, a_seed_in, a_req, a_ack);
      mb = mdl_next(mb, 16, b_reset, b_seed_load, b_seed_in, b_req, b_ack);
      chk($sformatf("rand%0d a grant", c), 32'(a_grant), 32'(mgrant(ma)));
      chk($sformatf("rand%0d a valid", c), 32'(a_rnd_valid), 32'(ma.valid));
      chk($sformatf("rand%0d a rnd", c),   32'(a_rnd_out), 32'(ma.rnd));
      chk($sformatf("rand%0d a busy", c),  32'(a_busy), 32'(ma.busy));
      chk($sformatf("rand%0d a lfsr", c),  32'(a_lfsr), 32'(ma.lfsr));
      chk($sformatf("rand%0d b grant", c), 32'(b_grant), 32'(mgrant(mb)));
      chk($sformatf("rand%0d b valid", c), 32'(b_rnd_valid), 32'(mb.valid));
      chk($sformatf("rand%0d b rnd", c),   32'(b_rnd_out), 32'(mb.rnd));
      chk($sformatf("rand%0d b busy", c),  32'(b_busy), 32'(mb.busy));
      chk($sformatf("rand%0d b lfsr", c),  32'(b_lfsr), 32'(mb.lfsr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
# lfsr_rng_arbiter

Shared random-number service built around one 16-bit Fibonacci LFSR. It arbitrates round-robin between NUM_REQ requesters. It advances the LFSR STEPS times per grant so that each delivered word is fresh, and it hands the word to the granted requester over a valid/ack handshake. The block sits between the LFSR datapath and every consumer of random data, and it also owns seeding of the generator.

## Interface
- NUM_REQ, default 4: number of requesters (2..8).
- STEPS, default 16: LFSR shifts per delivered word (1..255).
- SEED, default 16'h5678: reset seed, also used as the substitute for a zero seed.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, level-sensitive.
- ack  in  NUM_REQ  per-requester acceptance; only the bit of the granted requester is honoured.
- grant  out  NUM_REQ  one-hot grant, held from RUN entry until the ack cycle.
- rnd_out  out  16  delivered random word, stable while rnd_valid=1.
- rnd_valid  out  1  rnd_out is valid for the granted requester.
- seed_load  in  1  load seed_in into the LFSR; honoured in IDLE only.
- seed_in  in  16  seed value.
- busy  out  1  FSM is not in IDLE.
- lfsr_state  out  16  current LFSR register, for debug.

## Operation
- LFSR step: feedback = s[15]^s[13]^s[12]^s[10], and s <= {s[14:0], feedback} (polynomial x^16+x^14+x^13+x^11+1). The register is updated only in RUN or on a seed load.
- Reset values: lfsr=SEED, state=IDLE, grant=0, rnd_valid=0, rnd_out=0, busy=0. The round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, RUN, DELIVER.
- IDLE:
  - seed_load=1 has priority over req. The LFSR loads seed_in, or SEED if seed_in==0, and the FSM stays in IDLE.
  - Otherwise, if req!=0, the block picks the first asserted req scanning from pointer+1 with wrap. It sets grant one-hot, clears step_cnt and moves to RUN.
- RUN:
  - The LFSR steps every cycle and step_cnt increments.
  - In the cycle where step_cnt==STEPS-1, the block registers the stepped value into rnd_out, sets rnd_valid and moves to DELIVER.
- DELIVER:
  - rnd_valid=1 and rnd_out holds; the LFSR holds.
  - On ack[granted]=1, the block clears grant and rnd_valid, sets the pointer to the granted index and returns to IDLE.
  - ack bits of non-granted requesters are ignored.
- Boundary rules:
  - req dropped after grant: the transaction still completes and waits for ack; there is no abort.
  - seed_load while busy: ignored, not queued.
  - Simultaneous seed_load and req in IDLE: the seed is loaded this cycle and the request is served next cycle.
  - A zero LFSR state can never occur, because both the reset path and the seed path exclude zero.
  - Reset in any state: immediate return to reset values next edge. Any in-flight word is discarded with no valid pulse.
  - A single requester holding req continuously is served every STEPS+2 cycles. Other pending requesters are interleaved round-robin; no requester starves.

## Timing
- Clock edges:
  - req sampled in IDLE at edge t gives grant valid from t+1 (RUN).
  - rnd_valid rises at t+1+STEPS.
  - ack at edge u gives grant=0 and rnd_valid=0 from u+1, with the FSM in IDLE.
- IDLE lasts at least one cycle between transactions, so the minimum period is STEPS+2 cycles with same-cycle ack.
- busy=1 exactly while the state is RUN or DELIVER.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then STEPS=1 and req=4'b0001 held one cycle: grant=0001 next cycle; rnd_out=16'hACF0 with rnd_valid=1 after 1 RUN cycle; ack[0] clears both outputs.
- Back-to-back: same configuration, second req[0] after the first ack gives rnd_out=16'h59E1.
- Round-robin: STEPS=16 with req=4'b1111 held and ack returned in the same cycle as each valid. Grants must run in the order 0001, 0010, 0100, 1000, 0001, with rnd_valid spaced 18 cycles apart.
- Seed:
  - seed_load with seed_in=16'h0001 in IDLE, then a request with STEPS=1, gives rnd_out=16'h0002.
  - seed_in=0 gives lfsr_state=16'h5678.
  - seed_load during RUN leaves lfsr_state sequence unaffected.
- Wrong ack and slow consumer: granted requester 2, ack[1] pulsed, then ack[2] held low for 10 cycles. rnd_valid and rnd_out must stay stable and grant must stay 0100 until ack[2].
- Reset mid-RUN with STEPS=16, asserted on RUN cycle 5: next cycle grant=0, rnd_valid=0, lfsr_state=16'h5678, busy=0; the next req is served starting from requester 0.
